rio_link_tx_sched: RTL and testbench
====================================

# rio_link_tx_sched

Transmit-side word scheduler for the RocketIO/GTP serial link: it owns the 16-bit TX lane and decides, every cycle, which word goes on it. Candidates are a SYNC character, a SKIP character for clock compensation, a downstream credit word, a framed user packet (SOP char, data words, EOP char) or IDLE fill. It sits between the user TX packet interface / credit generator and the GTP TX port. Its framing matches the link RX controller exactly: K-characters in the upper byte, and raw credit words only between packets.

## Interface
- DATA_WIDTH, 16: lane width; the block supports 16 only.
- CREDIT_WIDTH, 16: credit word width; equals DATA_WIDTH.
- RIO_COMMA_CHAR, 8'hbc: K28.5, lower byte of every control word.
- RIO_SYN_CHAR, 8'hf7 / RIO_SKP_CHAR, 8'hfb / RIO_SOP_CHAR, 8'hfd / RIO_EOP_CHAR, 8'hfe: upper-byte K-chars.
- RIO_IDLE_CHAR, 8'hbc: upper byte of the IDLE word.
- SKP_PERIOD, 5000: cycles between SKIP requests; range 16..65535.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_link_up  in  1  local RX link up.
- i_credit  in  16  credit value to send.
- i_credit_valid  in  1  credit pending; held stable until acked.
- o_credit_ack  out  1  credit word scheduled this cycle.
- i_tx_valid  in  1  user beat valid.
- i_tx_sop / i_tx_eop  in  1  first / last beat of packet.
- i_tx_data  in  16  user beat.
- o_tx_ready  out  1  beat accepted when valid & ready.
- o_rio_tx_data  out  16  word to GTP.
- o_rio_tx_isk  out  2  K flags to GTP.
- o_underrun  out  1  pulse: valid low inside a packet.
- o_proto_err  out  1  pulse: beat without sop in IDLE, or sop inside packet.

## Operation
- Control words: SYN={F7,BC}, SKP={FB,BC}, SOP={FD,BC}, EOP={FE,BC}, IDLE={BC,BC}. Each has isk=2'b11. Data and credit words have isk=2'b00.
- States: T_SYNC, T_IDLE, T_SOP, T_DATA, T_EOP, T_DROP (one-hot).
- T_SYNC: emit SYN every cycle, o_tx_ready=0. Move to T_IDLE when i_link_up=1.
- T_IDLE: per-cycle priority is as follows.
  - skip_pending: emit SKP and clear skip_pending.
  - Otherwise, i_credit_valid: emit i_credit with isk 00 and pulse o_credit_ack.
  - Otherwise, i_tx_valid & i_tx_sop: emit SOP word and go to T_SOP. The beat is not consumed.
  - Otherwise, i_tx_valid & !i_tx_sop: consume it (ready=1), drop it and pulse o_proto_err.
  - Otherwise: emit IDLE.
- T_SOP: ready=1. Emit i_tx_data as the first beat. If i_tx_eop, go to T_EOP; else go to T_DATA.
- T_DATA: ready=1.
  - A valid beat emits i_tx_data. eop goes to T_EOP.
  - A beat with sop=1 inside a packet is still emitted as data and pulses o_proto_err.
  - valid=0 emits IDLE and pulses o_underrun. The upstream is store-and-forward, so this is a contract violation.
- T_EOP: emit EOP word, ready=0, then go to T_IDLE. Credits and SKIP wait for T_IDLE.
- skip counter (16b): counts in every state except T_SYNC. At SKP_PERIOD-1 it sets skip_pending and wraps to 0. skip_pending stays set until the SKP is emitted. SKP is never inserted inside a packet.
- Link loss: i_link_up=0 in any state forces SYN emission on the next word. Next state is as follows.
  - From T_SOP/T_DATA with the packet not finished: go to T_DROP.
  - From any other state: go to T_SYNC.
  - From T_EOP: the EOP word is replaced by SYN.
- T_DROP: emit SYN, ready=1, discard beats until the eop beat, then go to T_SYNC. If i_link_up returns during T_DROP, the drop still completes.
- Credits are never acked in T_SYNC or T_DROP.

## Timing
- The decision is combinational. o_rio_tx_data and o_rio_tx_isk are registered: the word chosen in cycle N appears in cycle N+1.
- o_tx_ready and o_credit_ack are combinational from state and inputs.
- o_underrun and o_proto_err are registered: they pulse in cycle N+1 for one cycle.
- Reset values: state T_SYNC, o_rio_tx_data=16'hF7BC, o_rio_tx_isk=2'b11, o_tx_ready=0, o_credit_ack=0, error pulses 0, skip counter 0, skip_pending 0.
- An n-beat packet occupies n+2 lane cycles: SOP, n data, EOP. Packets are back-to-back with no forced gap beyond T_EOP→T_IDLE. The minimum spacing between SOPs is therefore n+2.
- A skip request raised mid-packet is served by the first T_IDLE cycle after EOP. Its worst-case delay equals the maximum packet length + 2.
- A simultaneous skip_pending and credit send SKP first, then the credit next cycle.
- A credit pending together with a packet start sends the credit first.

## Test plan
- Reset, i_link_up=0 for 20 cycles, then 1 → SYN (F7BC/11) on every word; the first IDLE (BCBC/11) appears 2 cycles after i_link_up rises.
- 3-beat packet 0x1111,0x2222,0x3333 in T_IDLE → lane shows FDBC/11, 1111/00, 2222/00, 3333/00, FEBC/11, then BCBC. Ready is high for exactly 3 cycles. Also check a 1-beat packet gives FD, data, FE.
- i_credit=0x0042 valid together with sop beat → lane shows 0042/00 with o_credit_ack for 1 cycle, then FDBC; the packet follows intact.
- SKP_PERIOD=16 with a 30-beat packet starting at cycle 10 → no FBBC inside the packet; exactly one FBBC immediately after FEBC; the next SKP follows 16 cycles after the previous request.
- Drop i_link_up mid-packet at beat 4 of 10 → next word F7BC; remaining 6 beats consumed with no lane data; state returns to SYNC; re-raising link gives a clean IDLE.
- Deassert valid for 1 cycle mid-packet → BCBC on the lane in that slot and o_underrun pulses once; a non-sop beat in IDLE is dropped with o_proto_err=1.

Source files
------------

// File: rtl/rio_link_tx_sched.sv
// rio_link_tx_sched: TX lane word scheduler for the RocketIO/GTP link.
// Chooses SYNC, SKIP, credit, framed packet words or IDLE every cycle.
module rio_link_tx_sched #(
   parameter int         DATA_WIDTH     = 16,
   parameter int         CREDIT_WIDTH   = 16,
   parameter logic [7:0] RIO_COMMA_CHAR = 8'hbc,
   parameter logic [7:0] RIO_SYN_CHAR   = 8'hf7,
   parameter logic [7:0] RIO_SKP_CHAR   = 8'hfb,
   parameter logic [7:0] RIO_SOP_CHAR   = 8'hfd,
   parameter logic [7:0] RIO_EOP_CHAR   = 8'hfe,
   parameter logic [7:0] RIO_IDLE_CHAR  = 8'hbc,
   parameter int         SKP_PERIOD     = 5000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_link_up,
   input  logic [CREDIT_WIDTH-1:0] i_credit,
   input  logic                    i_credit_valid,
   output logic                    o_credit_ack,
   input  logic                    i_tx_valid,
   input  logic                    i_tx_sop,
   input  logic                    i_tx_eop,
   input  logic [DATA_WIDTH-1:0]   i_tx_data,
   output logic                    o_tx_ready,
   output logic [DATA_WIDTH-1:0]   o_rio_tx_data,
   output logic [1:0]              o_rio_tx_isk,
   output logic                    o_underrun,
   output logic                    o_proto_err
);

   typedef enum logic [5:0] {
      T_SYNC = 6'b000001,
      T_IDLE = 6'b000010,
      T_SOP  = 6'b000100,
      T_DATA = 6'b001000,
      T_EOP  = 6'b010000,
      T_DROP = 6'b100000
   } state_t;

   localparam logic [DATA_WIDTH-1:0] W_SYN  = {RIO_SYN_CHAR, RIO_COMMA_CHAR};
   localparam logic [DATA_WIDTH-1:0] W_SKP  = {RIO_SKP_CHAR, RIO_COMMA_CHAR};
   localparam logic [DATA_WIDTH-1:0] W_SOP  = {RIO_SOP_CHAR, RIO_COMMA_CHAR};
   localparam logic [DATA_WIDTH-1:0] W_EOP  = {RIO_EOP_CHAR, RIO_COMMA_CHAR};
   localparam logic [DATA_WIDTH-1:0] W_IDLE = {RIO_IDLE_CHAR, RIO_COMMA_CHAR};
   localparam logic [15:0]           SKP_MAX = 16'(SKP_PERIOD - 1);

   state_t                  r_state;
   state_t                  w_next;
   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic [1:0]              r_tx_isk;
   logic                    r_underrun;
   logic                    r_proto_err;
   logic [15:0]             r_skip_cnt;
   logic                    r_skip_pend;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [1:0]              w_isk;
   logic                    w_skip_clr;
   logic                    w_skip_hit;
   logic                    w_under;
   logic                    w_perr;

   assign w_skip_hit = (r_state != T_SYNC) && (r_skip_cnt == SKP_MAX);

   always_comb begin
      w_next       = r_state;
      w_data       = W_SYN;
      w_isk        = 2'b11;
      w_skip_clr   = 1'b0;
      w_under      = 1'b0;
      w_perr       = 1'b0;
      o_tx_ready   = 1'b0;
      o_credit_ack = 1'b0;
      unique case (r_state)
         T_SYNC: begin
            if (i_link_up) w_next = T_IDLE;
         end
         T_IDLE: begin
            if (!i_link_up) begin
               w_next = T_SYNC;
            end else if (r_skip_pend) begin
               w_data     = W_SKP;
               w_skip_clr = 1'b1;
            end else if (i_credit_valid) begin
               w_data       = i_credit;
               w_isk        = 2'b00;
               o_credit_ack = 1'b1;
            end else if (i_tx_valid && i_tx_sop) begin
               w_data = W_SOP;
               w_next = T_SOP;
            end else if (i_tx_valid) begin
               w_data     = W_IDLE;
               o_tx_ready = 1'b1;
               w_perr     = 1'b1;
            end else begin
               w_data = W_IDLE;
            end
         end
         T_SOP, T_DATA: begin
            o_tx_ready = 1'b1;
            // on link loss the beat in flight is consumed and discarded
            if (!i_link_up) begin
               w_next = (i_tx_valid && i_tx_eop) ? T_SYNC : T_DROP;
            end else if (i_tx_valid) begin
               w_data = i_tx_data;
               w_isk  = 2'b00;
               w_perr = (r_state == T_DATA) && i_tx_sop;
               w_next = i_tx_eop ? T_EOP : T_DATA;
            end else begin
               w_data  = W_IDLE;
               w_under = 1'b1;
            end
         end
         T_EOP: begin
            if (i_link_up) begin
               w_data = W_EOP;
               w_next = T_IDLE;
            end else begin
               w_next = T_SYNC;
            end
         end
         T_DROP: begin
            o_tx_ready = 1'b1;
            if (i_tx_valid && i_tx_eop) w_next = T_SYNC;
         end
         default: w_next = T_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= T_SYNC;
         r_tx_data   <= W_SYN;
         r_tx_isk    <= 2'b11;
         r_underrun  <= 1'b0;
         r_proto_err <= 1'b0;
         r_skip_cnt  <= 16'd0;
         r_skip_pend <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_tx_data   <= w_data;
         r_tx_isk    <= w_isk;
         r_underrun  <= w_under;
         r_proto_err <= w_perr;
         if (r_state != T_SYNC)
            r_skip_cnt <= w_skip_hit ? 16'd0 : r_skip_cnt + 16'd1;
         // a fresh request wins over the clear of an older one
         r_skip_pend <= w_skip_hit | (r_skip_pend & ~w_skip_clr);
      end
   end

   assign o_rio_tx_data = r_tx_data;
   assign o_rio_tx_isk  = r_tx_isk;
   assign o_underrun    = r_underrun;
   assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_rio_link_tx_sched.sv
// Directed bench for rio_link_tx_sched (SKP_PERIOD=16).
// Each test resets the DUT and walks a cycle-exact lane trace.
module tb_rio_link_tx_sched;

   logic        clk;
   logic        rst;
   logic        i_link_up;
   logic [15:0] i_credit;
   logic        i_credit_valid;
   logic        o_credit_ack;
   logic        i_tx_valid;
   logic        i_tx_sop;
   logic        i_tx_eop;
   logic [15:0] i_tx_data;
   logic        o_tx_ready;
   logic [15:0] o_rio_tx_data;
   logic [1:0]  o_rio_tx_isk;
   logic        o_underrun;
   logic        o_proto_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [17:0] c_lane;
   logic        c_und, c_perr, c_rdy, c_ack;

   rio_link_tx_sched #(.SKP_PERIOD(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_link_up      (i_link_up),
      .i_credit       (i_credit),
      .i_credit_valid (i_credit_valid),
      .o_credit_ack   (o_credit_ack),
      .i_tx_valid     (i_tx_valid),
      .i_tx_sop       (i_tx_sop),
      .i_tx_eop       (i_tx_eop),
      .i_tx_data      (i_tx_data),
      .o_tx_ready     (o_tx_ready),
      .o_rio_tx_data  (o_rio_tx_data),
      .o_rio_tx_isk   (o_rio_tx_isk),
      .o_underrun     (o_underrun),
      .o_proto_err    (o_proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset;
      rst = 1'b1;
      i_link_up = 1'b0;
      i_credit = 16'h0;
      i_credit_valid = 1'b0;
      i_tx_valid = 1'b0;
      i_tx_sop = 1'b0;
      i_tx_eop = 1'b0;
      i_tx_data = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // one lane cycle: capture registered outputs, drive inputs, capture comb outputs
   task automatic cyc(input logic lk, input logic cv, input logic v,
                      input logic s, input logic e, input logic [15:0] d);
      @(posedge clk);
      #1;
      c_lane = {o_rio_tx_isk, o_rio_tx_data};
      c_und  = o_underrun;
      c_perr = o_proto_err;
      i_link_up = lk;
      i_credit_valid = cv;
      i_tx_valid = v;
      i_tx_sop = s;
      i_tx_eop = e;
      i_tx_data = d;
      #1;
      c_rdy = o_tx_ready;
      c_ack = o_credit_ack;
   endtask

   task automatic test_reset;
      do_reset();
      n_tests++;
      if ({o_rio_tx_isk, o_rio_tx_data} !== 18'h3F7BC) begin
         n_fail++;
         $display("FAIL reset_lane got %h want 3f7bc", {o_rio_tx_isk, o_rio_tx_data});
      end
      n_tests++;
      if ({o_tx_ready, o_credit_ack, o_underrun, o_proto_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 0000",
                  {o_tx_ready, o_credit_ack, o_underrun, o_proto_err});
      end
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
         n_tests++;
         if (c_lane !== 18'h3F7BC || c_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_word[%0d] got %h rdy %b want 3f7bc rdy 0", i, c_lane, c_rdy);
         end
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      n_tests++;
      if (c_lane !== 18'h3F7BC) begin
         n_fail++;
         $display("FAIL linkup_plus1 got %h want 3f7bc", c_lane);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      n_tests++;
      if (c_lane !== 18'h3BCBC) begin
         n_fail++;
         $display("FAIL first_idle got %h want 3bcbc", c_lane);
      end
   endtask

   task automatic test_packet;
      logic        tv [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
      logic        ts [11] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
      logic        te [11] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
      logic [15:0] td [11] = '{16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0,
                               16'hABCD, 16'hABCD, 16'h0, 16'h0, 16'h0};
      logic [17:0] xl [11] = '{18'h3F7BC, 18'h3FDBC, 18'h01111, 18'h02222, 18'h03333,
                               18'h3FEBC, 18'h3BCBC, 18'h3FDBC, 18'h0ABCD, 18'h3FEBC,
                               18'h3BCBC};
      logic        xr [11] = '{0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0};
      int rdy_cnt = 0;
      do_reset();
      i_link_up = 1'b1;
      for (int i = 0; i < 11; i++) begin
         cyc(1'b1, 1'b0, tv[i], ts[i], te[i], td[i]);
         if (i < 6 && c_rdy === 1'b1) rdy_cnt++;
         n_tests++;
         if (c_lane !== xl[i]) begin
            n_fail++;
            $display("FAIL pkt_lane[%0d] got %h want %h", i, c_lane, xl[i]);
         end
         n_tests++;
         if (c_rdy !== xr[i]) begin
            n_fail++;
            $display("FAIL pkt_ready[%0d] got %b want %b", i, c_rdy, xr[i]);
         end
      end
      n_tests++;
      if (rdy_cnt != 3) begin
         n_fail++;
         $display("FAIL pkt_ready_count got %0d want 3", rdy_cnt);
      end
   endtask

   task automatic test_credit_first;
      logic        tc [6] = '{1, 0, 0, 0, 0, 0};
      logic        tv [6] = '{1, 1, 1, 0, 0, 0};
      logic [17:0] xl [6] = '{18'h3F7BC, 18'h00042, 18'h3FDBC, 18'h05555,
                              18'h3FEBC, 18'h3BCBC};
      logic        xr [6] = '{0, 0, 1, 0, 0, 0};
      logic        xa [6] = '{1, 0, 0, 0, 0, 0};
      do_reset();
      i_link_up = 1'b1;
      i_credit = 16'h0042;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, tc[i], tv[i], tv[i], tv[i], 16'h5555);
         n_tests++;
         if (c_lane !== xl[i] || c_rdy !== xr[i] || c_ack !== xa[i]) begin
            n_fail++;
            $display("FAIL credit[%0d] got %h rdy %b ack %b want %h rdy %b ack %b",
                     i, c_lane, c_rdy, c_ack, xl[i], xr[i], xa[i]);
         end
      end
   endtask

   task automatic test_skip;
      logic [17:0] lane [64];
      int j;
      int n_skp;
      do_reset();
      i_link_up = 1'b1;
      i_credit = 16'h0077;
      for (int k = 1; k <= 52; k++) begin
         j = (k <= 11) ? 1 : k - 10;
         cyc(1'b1, (k == 49 || k == 50), (k >= 10 && k <= 40), (j == 1), (j == 30),
             16'h1000 + 16'(j));
         lane[k] = c_lane;
         if (k == 49 || k == 50) begin
            n_tests++;
            if (c_ack !== (k == 50)) begin
               n_fail++;
               $display("FAIL skip_credit_ack[%0d] got %b want %b", k, c_ack, (k == 50));
            end
         end
      end
      n_skp = 0;
      for (int k = 1; k <= 42; k++) if (lane[k] === 18'h3FBBC) n_skp++;
      n_tests++;
      if (n_skp != 0) begin
         n_fail++;
         $display("FAIL skp_before_eop got %0d want 0", n_skp);
      end
      n_tests++;
      if (lane[11] !== 18'h3FDBC) begin
         n_fail++;
         $display("FAIL skip_sop got %h want 3fdbc", lane[11]);
      end
      for (int b = 1; b <= 30; b++) begin
         n_tests++;
         if (lane[11+b] !== {2'b00, 16'h1000 + 16'(b)}) begin
            n_fail++;
            $display("FAIL skip_beat[%0d] got %h want %h", b, lane[11+b],
                     {2'b00, 16'h1000 + 16'(b)});
         end
      end
      n_tests++;
      if (lane[42] !== 18'h3FEBC || lane[43] !== 18'h3FBBC) begin
         n_fail++;
         $display("FAIL skp_after_eop got %h %h want 3febc 3fbbc", lane[42], lane[43]);
      end
      n_skp = 0;
      for (int k = 44; k <= 49; k++) if (lane[k] !== 18'h3BCBC) n_skp++;
      n_tests++;
      if (n_skp != 0) begin
         n_fail++;
         $display("FAIL skip_gap_idle got %0d non-idle want 0", n_skp);
      end
      n_tests++;
      if (lane[50] !== 18'h3FBBC) begin
         n_fail++;
         $display("FAIL skp_second got %h want 3fbbc", lane[50]);
      end
      n_tests++;
      if (lane[51] !== 18'h00077) begin
         n_fail++;
         $display("FAIL skp_then_credit got %h want 00077", lane[51]);
      end
   endtask

   task automatic test_link_drop;
      logic [17:0] lane [20];
      logic        rdy  [20];
      int j;
      int n_bad;
      int n_rdy;
      do_reset();
      i_link_up = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         j = (k <= 2) ? 1 : k - 1;
         cyc(!(k >= 6 && k <= 13), 1'b0, (k <= 11), (j == 1), (j == 10),
             16'hA000 + 16'(j));
         lane[k] = c_lane;
         rdy[k] = c_rdy;
      end
      n_tests++;
      if (lane[2] !== 18'h3FDBC) begin
         n_fail++;
         $display("FAIL drop_sop got %h want 3fdbc", lane[2]);
      end
      for (int b = 1; b <= 4; b++) begin
         n_tests++;
         if (lane[2+b] !== {2'b00, 16'hA000 + 16'(b)}) begin
            n_fail++;
            $display("FAIL drop_beat[%0d] got %h want %h", b, lane[2+b],
                     {2'b00, 16'hA000 + 16'(b)});
         end
      end
      n_bad = 0;
      for (int k = 7; k <= 15; k++) if (lane[k] !== 18'h3F7BC) n_bad++;
      n_tests++;
      if (n_bad != 0) begin
         n_fail++;
         $display("FAIL drop_sync_words got %0d non-sync want 0", n_bad);
      end
      n_rdy = 0;
      for (int k = 6; k <= 11; k++) if (rdy[k] === 1'b1) n_rdy++;
      n_tests++;
      if (n_rdy != 6) begin
         n_fail++;
         $display("FAIL drop_consumed got %0d want 6", n_rdy);
      end
      n_tests++;
      if (rdy[12] !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_back_to_sync ready got %b want 0", rdy[12]);
      end
      n_tests++;
      if (lane[16] !== 18'h3BCBC) begin
         n_fail++;
         $display("FAIL drop_relink_idle got %h want 3bcbc", lane[16]);
      end
   endtask

   task automatic test_underrun_proto;
      logic        tv [9] = '{1, 1, 0, 1, 0, 1, 0, 0, 0};
      logic        ts [9] = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
      logic        te [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
      logic [15:0] td [9] = '{16'h0101, 16'h0101, 16'h0, 16'h0202, 16'h0,
                              16'hDEAD, 16'h0, 16'h0, 16'h0};
      logic [17:0] xl [9] = '{18'h3F7BC, 18'h3FDBC, 18'h00101, 18'h3BCBC, 18'h00202,
                              18'h3FEBC, 18'h3BCBC, 18'h3BCBC, 18'h3BCBC};
      logic        xu [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
      logic        xp [9] = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
      int n_und = 0;
      do_reset();
      i_link_up = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 1'b0, tv[i], ts[i], te[i], td[i]);
         if (c_und === 1'b1) n_und++;
         n_tests++;
         if (c_lane !== xl[i]) begin
            n_fail++;
            $display("FAIL urun_lane[%0d] got %h want %h", i, c_lane, xl[i]);
         end
         n_tests++;
         if (c_und !== xu[i] || c_perr !== xp[i]) begin
            n_fail++;
            $display("FAIL urun_flags[%0d] got und %b perr %b want und %b perr %b",
                     i, c_und, c_perr, xu[i], xp[i]);
         end
         if (i == 5) begin
            n_tests++;
            if (c_rdy !== 1'b1) begin
               n_fail++;
               $display("FAIL idle_drop_ready got %b want 1", c_rdy);
            end
         end
      end
      n_tests++;
      if (n_und != 1) begin
         n_fail++;
         $display("FAIL underrun_count got %0d want 1", n_und);
      end
   endtask

   initial begin
      test_reset();
      test_packet();
      test_credit_first();
      test_skip();
      test_link_drop();
      test_underrun_proto();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
